tff_consistency_monitor: RTL and testbench
==========================================

Name: tff_consistency_monitor

Overview:
- Sits directly downstream of the T flip-flop block built from SR, JK and D flip-flops.
- Consumes that block's T input and its three outputs Q_SR, Q_JK and Q_D.
- Keeps a golden toggle model, compares all three implementations against it every cycle, and counts toggles and mismatches.
- Latches first-failure information and provides a majority-voted Q for downstream logic.

Parameters:
- CNT_W, 8, width of the toggle, cycle and error counters (all saturating).
- STOP_ON_FAULT, 1, 1 = cycle counter freezes in FAULT; 0 = keeps counting.

Ports:
- clk  input  1  clock shared with the upstream TFF block.
- rst  input  1  synchronous active-high reset; must be the same rst that drives the upstream TFF block.
- T  input  1  toggle input, exactly as applied to the upstream block.
- Q_SR  input  1  upstream output, SR-based implementation.
- Q_JK  input  1  upstream output, JK-based implementation.
- Q_D  input  1  upstream output, D-based implementation.
- start  input  1  pulse: arm checking.
- stop  input  1  pulse: disarm checking.
- clr_err  input  1  pulse: clear fault and error state.
- q_vote  output  1  combinational majority of Q_SR, Q_JK, Q_D.
- q_ref  output  1  golden model state.
- mismatch_vec  output  3  registered; bit2 = SR, bit1 = JK, bit0 = D; 1 = differed from q_ref on the last check.
- toggle_cnt  output  CNT_W  number of cycles with T=1 since reset (saturating).
- cyc_cnt  output  CNT_W  cycles spent checking (saturating).
- err_cnt  output  CNT_W  checked cycles with any mismatch (saturating).
- fault  output  1  sticky; high in FAULT state.
- first_fail_vec  output  3  mismatch pattern of the first failing cycle.
- first_fail_cyc  output  CNT_W  cyc_cnt value at the first failure.
- busy  output  1  high in CHECK or FAULT.

Behaviour:
- Reset (clk edge with rst=1):
  - q_ref=0, all counters=0, mismatch_vec=0, first_fail_*=0, fault=0, state=IDLE.
  - rst has priority over all other inputs.
- Golden model:
  - Every edge with rst=0: q_ref <= q_ref ^ T, regardless of state.
  - toggle_cnt increments when T=1 and saturates at all-ones.
- Alignment:
  - At edge k, the Q inputs hold the upstream state from edge k-1, and q_ref holds the model state from edge k-1.
  - The comparison at edge k is therefore the current Q_x against the current q_ref, evaluated before q_ref updates. Latency is zero cycles relative to the upstream register.
- Check:
  - In CHECK or FAULT, each edge sets mismatch_vec <= {Q_SR^q_ref, Q_JK^q_ref, Q_D^q_ref}.
  - In IDLE, mismatch_vec <= 0.
- err_cnt increments (saturating) when checking and any mismatch bit is 1.
- cyc_cnt increments (saturating) in CHECK. In FAULT it increments only if STOP_ON_FAULT=0.
- FSM states IDLE, CHECK, FAULT:
  - IDLE -> CHECK on start. cyc_cnt and err_cnt clear on this edge.
  - CHECK -> FAULT on the first mismatching check. On the same edge, first_fail_vec is captured and first_fail_cyc <= cyc_cnt (the value before increment).
  - CHECK -> IDLE on stop, unless a mismatch occurs on the same edge. A mismatch wins: the next state is FAULT.
  - FAULT -> IDLE on clr_err only. This clears err_cnt, first_fail_*, mismatch_vec and fault. stop is ignored in FAULT.
  - Simultaneous start and clr_err in FAULT: clr_err is taken and start is ignored. A second start is required.
  - start while in CHECK or FAULT is ignored.
- fault = (state == FAULT), registered.
- q_vote = (SR&JK)|(SR&D)|(JK&D). It is purely combinational, with no reset dependence.
- Reset mid-check: the monitor returns to IDLE with q_ref=0. Because the upstream block resets on the same edge to Q=0, the two remain aligned.

Decomposition:
- Shared package tff_mon_pkg holds:
  - state enum {IDLE, CHECK, FAULT};
  - index constants IDX_SR=2, IDX_JK=1, IDX_D=0;
  - a saturating-increment function.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, clr, inc; output cnt), instantiated for toggle_cnt, cyc_cnt and err_cnt.

Test Plan:
- Healthy run:
  - Stimulus: reset 1 cycle, start, then T per cycle 1,1,0,0,1,0,1,1,0.
  - Required: q_ref sequence 1,0,0,0,1,1,0,1,1; fault=0; err_cnt=0; toggle_cnt=5; cyc_cnt=9.
- Injected SR fault:
  - Stimulus: force Q_SR inverted at check cycle 3.
  - Required: mismatch_vec=3'b100, fault=1 the next cycle, first_fail_vec=3'b100, first_fail_cyc=3, q_vote still equals q_ref.
- Double fault:
  - Stimulus: force Q_JK and Q_D stuck at 0 while q_ref=1.
  - Required: mismatch_vec=3'b011, q_vote=0, err_cnt increments each such cycle.
- Clear/start collision:
  - Stimulus: in FAULT, assert clr_err and start on the same edge.
  - Required: state=IDLE, busy=0, err_cnt=0; a following start enters CHECK.
- Stop vs mismatch:
  - Stimulus: stop asserted on the same edge as a mismatch.
  - Required: state=FAULT, not IDLE.
- Saturation and reset:
  - Stimulus: CNT_W=4, T=1 for 20 cycles.
  - Required: toggle_cnt=15 and holds; rst mid-check gives q_ref=0, all counters 0, state IDLE.

Source files
------------

// File: rtl/tff_mon_pkg.sv
// Shared types and helpers for the TFF consistency monitor.
package tff_mon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StFault
  } mon_state_e;

  // Bit positions of each upstream implementation in mismatch vectors.
  localparam int unsigned IdxSr = 2;
  localparam int unsigned IdxJk = 1;
  localparam int unsigned IdxD  = 0;

  // Increment val, clamping at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear (clear wins).
module sat_counter
  import tff_mon_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats increment; increment sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = W'(sat_inc(32'(cnt_q), W));
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tff_consistency_monitor.sv
// Checks the SR/JK/D-based T flip-flop outputs against a golden toggle model,
// counts toggles and mismatches, and latches first-failure information.
module tff_consistency_monitor
  import tff_mon_pkg::*;
#(
  parameter int unsigned CNT_W         = 8,
  parameter bit          STOP_ON_FAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             T,
  input  logic             Q_SR,
  input  logic             Q_JK,
  input  logic             Q_D,
  input  logic             start,
  input  logic             stop,
  input  logic             clr_err,
  output logic             q_vote,
  output logic             q_ref,
  output logic [2:0]       mismatch_vec,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fault,
  output logic [2:0]       first_fail_vec,
  output logic [CNT_W-1:0] first_fail_cyc,
  output logic             busy
);

  mon_state_e       state_q;
  logic             q_ref_q;
  logic [2:0]       mm_now;
  logic             any_mm;
  logic [2:0]       mm_q;
  logic [2:0]       ff_vec_q;
  logic [CNT_W-1:0] ff_cyc_q;
  logic             fault_q;

  logic             start_acc;
  logic             clr_acc;
  logic             cyc_inc;
  logic             err_clr;
  logic             err_inc;

  // Compare the upstream state against the model before the model advances.
  always_comb begin
    mm_now        = '0;
    mm_now[IdxSr] = Q_SR ^ q_ref_q;
    mm_now[IdxJk] = Q_JK ^ q_ref_q;
    mm_now[IdxD]  = Q_D ^ q_ref_q;
    any_mm        = |mm_now;
  end

  // Counter controls derived from the current state and pulses.
  always_comb begin
    start_acc = (state_q == StIdle) && start;
    clr_acc   = (state_q == StFault) && clr_err;
    cyc_inc   = (state_q == StCheck) || ((state_q == StFault) && !STOP_ON_FAULT);
    err_clr   = start_acc || clr_acc;
    err_inc   = (state_q != StIdle) && any_mm;
  end

  // Golden model: toggles on T in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_ref_q <= 1'b0;
    end else begin
      q_ref_q <= q_ref_q ^ T;
    end
  end

  // Monitor FSM with registered mismatch, fault and first-failure outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mm_q     <= '0;
      ff_vec_q <= '0;
      ff_cyc_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          mm_q    <= '0;
          fault_q <= 1'b0;
          if (start) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          mm_q <= mm_now;
          // A mismatch outranks a concurrent stop.
          if (any_mm) begin
            state_q  <= StFault;
            fault_q  <= 1'b1;
            ff_vec_q <= mm_now;
            ff_cyc_q <= cyc_cnt;
          end else if (stop) begin
            state_q <= StIdle;
          end
        end
        StFault: begin
          // Only clr_err leaves FAULT; a coincident start is dropped.
          if (clr_err) begin
            state_q  <= StIdle;
            mm_q     <= '0;
            ff_vec_q <= '0;
            ff_cyc_q <= '0;
            fault_q  <= 1'b0;
          end else begin
            mm_q <= mm_now;
          end
        end
        default: begin
          state_q <= StIdle;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_toggle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (T),
    .cnt (toggle_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_cyc_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .inc (cyc_inc),
    .cnt (cyc_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (err_clr),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  assign q_vote         = (Q_SR & Q_JK) | (Q_SR & Q_D) | (Q_JK & Q_D);
  assign q_ref          = q_ref_q;
  assign mismatch_vec   = mm_q;
  assign fault          = fault_q;
  assign first_fail_vec = ff_vec_q;
  assign first_fail_cyc = ff_cyc_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_tff_consistency_monitor.sv
// Bench for tff_consistency_monitor: a stop-on-fault 8-bit instance and a
// keep-counting 4-bit instance share stimulus and are checked against a model.
module tb_tff_consistency_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, T = 1'b0, Q_SR = 1'b0, Q_JK = 1'b0, Q_D = 1'b0;
  logic start = 1'b0, stop = 1'b0, clr_err = 1'b0;

  logic       a_q_vote, a_q_ref, a_fault, a_busy;
  logic [2:0] a_mm, a_ffv;
  logic [7:0] a_tog, a_cyc, a_err, a_ffc;
  logic       b_q_vote, b_q_ref, b_fault, b_busy;
  logic [2:0] b_mm, b_ffv;
  logic [3:0] b_tog, b_cyc, b_err, b_ffc;

  tff_consistency_monitor #(
    .CNT_W         (8),
    .STOP_ON_FAULT (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .T              (T),
    .Q_SR           (Q_SR),
    .Q_JK           (Q_JK),
    .Q_D            (Q_D),
    .start          (start),
    .stop           (stop),
    .clr_err        (clr_err),
    .q_vote         (a_q_vote),
    .q_ref          (a_q_ref),
    .mismatch_vec   (a_mm),
    .toggle_cnt     (a_tog),
    .cyc_cnt        (a_cyc),
    .err_cnt        (a_err),
    .fault          (a_fault),
    .first_fail_vec (a_ffv),
    .first_fail_cyc (a_ffc),
    .busy           (a_busy)
  );

  tff_consistency_monitor #(
    .CNT_W         (4),
    .STOP_ON_FAULT (1'b0)
  ) dut4 (
    .clk            (clk),
    .rst            (rst),
    .T              (T),
    .Q_SR           (Q_SR),
    .Q_JK           (Q_JK),
    .Q_D            (Q_D),
    .start          (start),
    .stop           (stop),
    .clr_err        (clr_err),
    .q_vote         (b_q_vote),
    .q_ref          (b_q_ref),
    .mismatch_vec   (b_mm),
    .toggle_cnt     (b_tog),
    .cyc_cnt        (b_cyc),
    .err_cnt        (b_err),
    .fault          (b_fault),
    .first_fail_vec (b_ffv),
    .first_fail_cyc (b_ffc),
    .busy           (b_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Upstream TFF stand-in plus fault injection knobs.
  logic up_q = 1'b0;
  logic sr_inv = 1'b0, jk_stuck0 = 1'b0, d_stuck0 = 1'b0;

  // Reference model: unbounded counts, saturated only when compared.
  localparam int MIdle = 0, MCheck = 1, MFault = 2;
  int       m_state = MIdle;
  logic     m_qref = 1'b0;
  logic [2:0] m_mm = 3'b000, m_ffv = 3'b000;
  int       m_tog = 0, m_cyc_a = 0, m_cyc_b = 0, m_err = 0, m_ffc = 0;
  bit       m_valid = 1'b0;

  function automatic int sat(input int x, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [2:0] mm;
    bit any;
    if (rst) begin
      m_state = MIdle; m_qref = 1'b0; m_mm = '0; m_ffv = '0;
      m_tog = 0; m_cyc_a = 0; m_cyc_b = 0; m_err = 0; m_ffc = 0;
      up_q = 1'b0; m_valid = 1'b1;
    end else begin
      mm  = {Q_SR != m_qref, Q_JK != m_qref, Q_D != m_qref};
      any = (mm != 3'b000);
      if (T) m_tog++;
      case (m_state)
        MIdle: begin
          m_mm = '0;
          if (start) begin
            m_state = MCheck; m_cyc_a = 0; m_cyc_b = 0; m_err = 0;
          end
        end
        MCheck: begin
          m_mm = mm;
          if (any) begin
            m_err++; m_ffv = mm; m_ffc = m_cyc_a; m_state = MFault;
          end else if (stop) begin
            m_state = MIdle;
          end
          m_cyc_a++; m_cyc_b++;
        end
        default: begin
          if (clr_err) begin
            m_state = MIdle; m_err = 0; m_ffv = '0; m_ffc = 0; m_mm = '0;
          end else begin
            m_mm = mm;
            if (any) m_err++;
          end
          m_cyc_b++;
        end
      endcase
      m_qref = m_qref ^ T;
      up_q   = up_q ^ T;
    end
  endtask

  task automatic compare_all();
    logic vote;
    vote = ((int'(Q_SR) + int'(Q_JK) + int'(Q_D)) >= 2);
    chk("a.q_vote", a_q_vote, vote);
    chk("a.q_ref", a_q_ref, m_qref);
    chk("a.mismatch_vec", a_mm, m_mm);
    chk("a.toggle_cnt", a_tog, sat(m_tog, 8));
    chk("a.cyc_cnt", a_cyc, sat(m_cyc_a, 8));
    chk("a.err_cnt", a_err, sat(m_err, 8));
    chk("a.fault", a_fault, m_state == MFault);
    chk("a.first_fail_vec", a_ffv, m_ffv);
    chk("a.first_fail_cyc", a_ffc, sat(m_ffc, 8));
    chk("a.busy", a_busy, m_state != MIdle);
    chk("b.q_vote", b_q_vote, vote);
    chk("b.q_ref", b_q_ref, m_qref);
    chk("b.mismatch_vec", b_mm, m_mm);
    chk("b.toggle_cnt", b_tog, sat(m_tog, 4));
    chk("b.cyc_cnt", b_cyc, sat(m_cyc_b, 4));
    chk("b.err_cnt", b_err, sat(m_err, 4));
    chk("b.fault", b_fault, m_state == MFault);
    chk("b.first_fail_vec", b_ffv, m_ffv);
    chk("b.first_fail_cyc", b_ffc, sat(m_ffc, 4));
    chk("b.busy", b_busy, m_state != MIdle);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (m_valid) compare_all();
  end

  // One clock: drive at the falling edge, return after the model check.
  task automatic tick(input logic t_v, input logic st, input logic sp, input logic cl,
                      input logic r);
    @(negedge clk);
    rst = r; T = t_v; start = st; stop = sp; clr_err = cl;
    Q_SR = up_q ^ sr_inv;
    Q_JK = jk_stuck0 ? 1'b0 : up_q;
    Q_D  = d_stuck0 ? 1'b0 : up_q;
    @(posedge clk);
    #2;
  endtask

  logic t_seq[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic q_seq[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    // Reset
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst.q_ref", a_q_ref, 0);
    chk("rst.toggle_cnt", a_tog, 0);
    chk("rst.busy", a_busy, 0);

    // Healthy run
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick(t_seq[i], 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("healthy.q_ref[%0d]", i), a_q_ref, q_seq[i]);
    end
    chk("healthy.fault", a_fault, 0);
    chk("healthy.err_cnt", a_err, 0);
    chk("healthy.toggle_cnt", a_tog, 5);
    chk("healthy.cyc_cnt", a_cyc, 9);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stop.busy", a_busy, 0);

    // SR inverted on the check where cyc_cnt reads 3
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sr_inv = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sr_inv = 1'b0;
    chk("sr.mismatch_vec", a_mm, 3'b100);
    chk("sr.fault", a_fault, 1);
    chk("sr.first_fail_vec", a_ffv, 3'b100);
    chk("sr.first_fail_cyc", a_ffc, 3);
    chk("sr.b_first_fail_cyc", b_ffc, 3);
    chk("sr.q_vote", a_q_vote, 1);

    // JK and D stuck at 0 while q_ref=1; stop must not leave FAULT
    jk_stuck0 = 1'b1; d_stuck0 = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dbl.mismatch_vec", a_mm, 3'b011);
    chk("dbl.q_vote", a_q_vote, 0);
    chk("dbl.err_cnt", a_err, 2);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dbl.err_cnt2", a_err, 3);
    chk("dbl.fault_after_stop", a_fault, 1);
    jk_stuck0 = 1'b0; d_stuck0 = 1'b0;

    // clr_err and start together: clear wins, start dropped
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("coll.busy", a_busy, 0);
    chk("coll.fault", a_fault, 0);
    chk("coll.err_cnt", a_err, 0);
    chk("coll.first_fail_vec", a_ffv, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("coll.restart_busy", a_busy, 1);
    chk("coll.restart_cyc", a_cyc, 0);

    // stop coinciding with a mismatch
    sr_inv = 1'b1;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sr_inv = 1'b0;
    chk("stopmm.fault", a_fault, 1);
    chk("stopmm.busy", a_busy, 1);
    chk("stopmm.mismatch_vec", a_mm, 3'b100);
    chk("stopmm.first_fail_cyc", a_ffc, 0);

    // Saturation
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat.b_toggle_cnt", b_tog, 15);
    chk("sat.b_cyc_cnt", b_cyc, 15);
    chk("sat.a_toggle_cnt", a_tog, 27);
    chk("sat.a_cyc_cnt", a_cyc, 20);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat.b_toggle_hold", b_tog, 15);

    // Reset mid-check, with start and T also high
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mrst.q_ref", a_q_ref, 0);
    chk("mrst.toggle_cnt", a_tog, 0);
    chk("mrst.b_toggle_cnt", b_tog, 0);
    chk("mrst.cyc_cnt", a_cyc, 0);
    chk("mrst.err_cnt", a_err, 0);
    chk("mrst.busy", a_busy, 0);
    chk("mrst.fault", a_fault, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post.q_ref", a_q_ref, 0);
    chk("post.fault", a_fault, 0);
    chk("post.cyc_cnt", a_cyc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
